// File: rtl/mlp_pkg.sv
// Shared constants and types for the MLP-Mixer datapath slice.
// Holds the MAC product width, the default dot-product length and the accumulator FSM encoding.
package mlp_pkg;

    localparam int PROD_W      = 16;
    localparam int VEC_LEN_DEF = 64;

    // Narrowest accumulator that cannot wrap when summing vec_len products of prod_w bits.
    function automatic int acc_w_min(input int prod_w, input int vec_len);
        return prod_w + $clog2(vec_len);
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

endpackage

// File: rtl/acc_outbuf.sv
// One-entry valid/ready holding register for completed dot products.
// A load into an occupied, non-draining entry is rejected and flagged on drop.
module acc_outbuf #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] data,
    input  logic         ready,
    output logic [W-1:0] q,
    output logic         valid,
    output logic         drop
);

    logic accept;

    assign accept = load && (!valid || ready);
    assign drop   = load && valid && !ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (accept) begin
            q     <= data;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product reduction stage behind the 8x8 MAC: sums VEC_LEN products per result
// and hands each sum to a single-entry valid/ready buffer. Never stalls the MAC.
module mac_accumulator #(
    parameter int VEC_LEN = mlp_pkg::VEC_LEN_DEF,
    parameter int PROD_W  = mlp_pkg::PROD_W,
    parameter int ACC_W   = 24,
    localparam int CNT_W  = $clog2(VEC_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [CNT_W-1:0]  term_idx,
    output logic              busy,
    output logic              overrun
);

    import mlp_pkg::*;

    if (VEC_LEN < 2 || VEC_LEN > 1024 || ACC_W < acc_w_min(PROD_W, VEC_LEN)) begin : g_bad_param
        $error("mac_accumulator: illegal VEC_LEN/ACC_W combination");
    end

    acc_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [ACC_W-1:0] acc, acc_nxt, sum;
    logic             last_term, res_drop;

    assign sum       = acc + ACC_W'(prod);
    assign last_term = prod_valid && !clear && (state == ACCUM) && (cnt == CNT_W'(VEC_LEN - 1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            acc_nxt   = '0;
        end else if (prod_valid) begin
            case (state)
                IDLE: begin
                    state_nxt = ACCUM;
                    cnt_nxt   = CNT_W'(1);
                    acc_nxt   = ACC_W'(prod);
                end
                ACCUM: begin
                    if (last_term) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        acc_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                        acc_nxt = sum;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    acc_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            if (res_drop) overrun <= 1'b1;
        end
    end

    // The final sum goes straight from the adder into the buffer: one cycle of latency.
    acc_outbuf #(.W(ACC_W)) u_outbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (last_term),
        .data  (sum),
        .ready (acc_ready),
        .q     (acc_out),
        .valid (acc_valid),
        .drop  (res_drop)
    );

    assign busy     = (state == ACCUM);
    assign term_idx = cnt;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a VEC_LEN=4 instance for control behaviour
// and a VEC_LEN=64/ACC_W=22 instance for the full-scale sum.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        clear_a, pv_a, rdy_a;
    logic [15:0] prod_a;
    logic [23:0] out_a;
    logic        vld_a, busy_a, ovr_a;
    logic [1:0]  idx_a;

    logic        clear_b, pv_b, rdy_b;
    logic [15:0] prod_b;
    logic [21:0] out_b;
    logic        vld_b, busy_b, ovr_b;
    logic [5:0]  idx_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_accumulator #(.VEC_LEN(4), .PROD_W(16), .ACC_W(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear_a), .prod_valid(pv_a), .prod(prod_a),
        .acc_out(out_a), .acc_valid(vld_a), .acc_ready(rdy_a),
        .term_idx(idx_a), .busy(busy_a), .overrun(ovr_a)
    );

    mac_accumulator #(.VEC_LEN(64), .PROD_W(16), .ACC_W(22)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_b), .prod_valid(pv_b), .prod(prod_b),
        .acc_out(out_b), .acc_valid(vld_b), .acc_ready(rdy_b),
        .term_idx(idx_b), .busy(busy_b), .overrun(ovr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one product to dut_a across the next rising edge.
    task automatic push_a(input logic [15:0] p);
        pv_a   = 1'b1;
        prod_a = p;
        @(negedge clk);
        pv_a   = 1'b0;
    endtask

    initial begin
        clear_a = 0; pv_a = 0; rdy_a = 1; prod_a = 0;
        clear_b = 0; pv_b = 0; rdy_b = 1; prod_b = 0;

        // Reset state, observed before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_acc_out",   out_a, 0);
        chk("rst_acc_valid", vld_a, 0);
        chk("rst_term_idx",  idx_a, 0);
        chk("rst_busy",      busy_a, 0);
        chk("rst_overrun",   ovr_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic sum 100+200+300+400 with acc_ready held high
        push_a(16'd100);
        chk("basic_busy1", busy_a, 1);
        chk("basic_idx1",  idx_a, 1);
        push_a(16'd200);
        push_a(16'd300);
        chk("basic_idx3",  idx_a, 3);
        chk("basic_vld_early", vld_a, 0);
        push_a(16'd400);
        chk("basic_vld",   vld_a, 1);
        chk("basic_sum",   out_a, 1000);
        chk("basic_busy0", busy_a, 0);
        chk("basic_idx0",  idx_a, 0);
        @(negedge clk);
        chk("basic_vld_drop", vld_a, 0);

        // Simultaneous drain and load: result 4 pending, final 2 arrives with ready
        rdy_a = 1'b0;
        repeat (4) push_a(16'd1);
        chk("sim_first_vld", vld_a, 1);
        chk("sim_first_sum", out_a, 4);
        repeat (3) push_a(16'd2);
        chk("sim_hold_vld", vld_a, 1);
        chk("sim_hold_sum", out_a, 4);
        rdy_a = 1'b1;
        push_a(16'd2);
        chk("sim_second_vld", vld_a, 1);
        chk("sim_second_sum", out_a, 8);
        chk("sim_overrun",    ovr_a, 0);
        @(negedge clk);
        chk("sim_drained", vld_a, 0);

        // Backpressure: two full vectors with ready low, second is dropped
        rdy_a = 1'b0;
        repeat (4) push_a(16'd1);
        chk("bp_first_sum", out_a, 4);
        chk("bp_no_ovr_yet", ovr_a, 0);
        repeat (4) push_a(16'd2);
        chk("bp_held_vld", vld_a, 1);
        chk("bp_held_sum", out_a, 4);
        chk("bp_overrun",  ovr_a, 1);
        rdy_a = 1'b1;
        @(negedge clk);
        chk("bp_accepted", vld_a, 0);
        @(negedge clk);
        chk("bp_no_second", vld_a, 0);
        chk("bp_sticky", ovr_a, 1);

        // Clear mid-vector: 5, 6, clear with 7, then 1,1,1,1
        push_a(16'd5);
        push_a(16'd6);
        chk("clr_idx_pre", idx_a, 2);
        clear_a = 1'b1;
        push_a(16'd7);
        clear_a = 1'b0;
        chk("clr_busy", busy_a, 0);
        chk("clr_idx",  idx_a, 0);
        chk("clr_vld",  vld_a, 0);
        repeat (3) push_a(16'd1);
        chk("clr_no_out", vld_a, 0);
        push_a(16'd1);
        chk("clr_vld_out", vld_a, 1);
        chk("clr_sum",     out_a, 4);
        chk("clr_ovr_kept", ovr_a, 1);
        @(negedge clk);

        // Full-scale sum on the wide instance: 64 x 65025
        pv_b   = 1'b1;
        prod_b = 16'd65025;
        repeat (63) @(negedge clk);
        chk("max_idx63", idx_b, 63);
        chk("max_vld_early", vld_b, 0);
        @(negedge clk);
        pv_b = 1'b0;
        chk("max_vld", vld_b, 1);
        chk("max_sum", out_b, 4161600);
        chk("max_ovr", ovr_b, 0);

        // Async reset mid-vector with a result pending
        rdy_a = 1'b0;
        repeat (4) push_a(16'd1);
        push_a(16'd5);
        push_a(16'd5);
        chk("ar_pending", vld_a, 1);
        chk("ar_busy_pre", busy_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_acc_out",   out_a, 0);
        chk("ar_acc_valid", vld_a, 0);
        chk("ar_term_idx",  idx_a, 0);
        chk("ar_busy",      busy_a, 0);
        chk("ar_overrun",   ovr_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_a = 1'b1;
        @(negedge clk);
        repeat (4) push_a(16'd3);
        chk("ar_after_vld", vld_a, 1);
        chk("ar_after_sum", out_a, 12);
        chk("ar_after_ovr", ovr_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Dot-product accumulator placed directly downstream of the 8x8 unsigned MAC pipeline. It consumes one 16-bit unsigned product per `prod_valid` strobe (driven by the MAC's `done`/`result`), sums `VEC_LEN` consecutive products into one vector result, and presents each result on a single-entry valid/ready output buffer. It is the reduction stage feeding the MLP-Mixer activation/writeback logic. Accumulation never stalls, because the MAC has no backpressure.

## Interface
Parameters:
- `VEC_LEN`, 64: number of products per dot product. Legal range is 2..1024.
- `PROD_W`, 16: product width. Must match the MAC result width.
- `ACC_W`, 24: accumulator and result width. Must satisfy ACC_W ≥ PROD_W + clog2(VEC_LEN). Elaboration fails otherwise.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort of the vector in progress.
- `prod_valid`  in  1  qualifies `prod` for one cycle. There is no ready; every strobe must be absorbed.
- `prod`  in  PROD_W  unsigned product.
- `acc_out`  out  ACC_W  completed dot-product sum. Held stable while `acc_valid`=1 and `acc_ready`=0.
- `acc_valid`  out  1  result available.
- `acc_ready`  in  1  downstream accepts. The transfer occurs on a cycle where `acc_valid` and `acc_ready` are both 1.
- `term_idx`  out  clog2(VEC_LEN)  index of the next expected term.
- `busy`  out  1  the vector in progress holds at least one term.
- `overrun`  out  1  sticky: a completed result was dropped. Cleared only by `rst_n`.

## Operation
- Internal state:
  - running sum `acc` (ACC_W bits, unsigned).
  - term counter `cnt`, with values 0..VEC_LEN-1.
  - FSM with states IDLE (cnt=0, acc=0) and ACCUM (cnt≥1).
  - output buffer register plus its valid bit.
- IDLE, with `prod_valid`: acc ← prod, cnt ← 1, go to ACCUM.
- ACCUM, with `prod_valid` and cnt < VEC_LEN-1: acc ← acc + prod, cnt ← cnt+1.
- ACCUM, with `prod_valid` and cnt = VEC_LEN-1 (final term):
  - the sum acc+prod is offered to the output buffer;
  - acc ← 0, cnt ← 0, go to IDLE.
- Buffer load rule: the buffer loads if it is empty, or if it is being drained in the same cycle.
  - Otherwise the new result is discarded, `overrun` ← 1, and the held result is kept unchanged.
- `clear` (priority over `prod_valid`):
  - acc ← 0, cnt ← 0, go to IDLE;
  - the same-cycle product is dropped;
  - the output buffer and `overrun` are unaffected.
- Arithmetic: unsigned, zero-extended to ACC_W. The parameter rule guarantees no wrap, so no saturation logic exists.
- `busy` = (state == ACCUM). `term_idx` = cnt.
- Reset values: `acc_out`=0, `acc_valid`=0, `term_idx`=0, `busy`=0, `overrun`=0. Internal acc=0, state IDLE.
- Reset asserted mid-vector discards partial sums and any buffered result immediately (asynchronous).

## Timing
- Latency: final `prod_valid` at edge t produces `acc_valid`=1 and the sum on `acc_out` after edge t+1 (one cycle).
- Back-to-back vectors: a new vector's first term may arrive in the cycle directly after the previous final term, with no bubble required.
- Full throughput: one product per cycle, indefinitely, provided the output drains at least once per VEC_LEN cycles.
- `acc_valid` drops the cycle after the handshake, unless a new result loads on that same edge (then it stays 1).
- Final term arriving in the same cycle as a completing handshake: the new result loads and `overrun` stays 0.
- `acc_ready` may be high while `acc_valid`=0; this has no effect.
- `acc_out` and `acc_valid` are registered outputs. There is no combinational path from `acc_ready` to `acc_valid`.

## Structure
- Shared package `mlp_pkg` holds:
  - `PROD_W` (16);
  - default `VEC_LEN`;
  - the `ACC_W` derivation as a constant function;
  - a 2-state FSM enum `acc_state_t` (IDLE, ACCUM).
- One sub-module `acc_outbuf`: a one-entry valid/ready holding register.
  - Inputs: load, data.
  - Outputs: an overflow-drop indication.
  - The top block derives the sticky `overrun` from it.
- Counter, adder and FSM live in the top module.

## Test plan
- Basic sum: VEC_LEN=4, `acc_ready`=1, products 100, 200, 300, 400 on consecutive cycles. Expect `acc_out`=1000 with `acc_valid` high for one cycle, one cycle after the 400; `busy` falls to 0 on the same edge.
- Maximum value: VEC_LEN=64, ACC_W=22, 64 products of 65025 (255×255). Expect `acc_out`=4161600 with no wrap.
- Backpressure and overrun, VEC_LEN=4:
  - hold `acc_ready`=0 and send two full vectors (1,1,1,1 then 2,2,2,2);
  - expect `acc_out`=4 held and `overrun`=1;
  - raise `acc_ready`: 4 is accepted, 8 is never presented.
- Simultaneous drain and load: the second vector's final term lands in the same cycle as `acc_ready`=1 on the first result. Expect both results delivered in order, `acc_valid` continuously high across the transition, `overrun`=0.
- Clear mid-vector, VEC_LEN=4:
  - send 5, 6, then `clear` together with product 7, then 1, 1, 1, 1;
  - expect `acc_out`=4, with no output from the aborted vector.
- Async reset: assert `rst_n`=0 mid-vector while a result is pending. Expect every output at its reset value immediately, without waiting for a clock edge; after release, the vector 3,3,3,3 gives 12.
